// File: rtl/result_matrix_collector.sv
// result_matrix_collector: captures strobed M x M results, flags completion, streams them out row-major.
// Optional duplicate-write protection is enabled by defining RESULT_DUP_CHECK_EN.
module result_matrix_collector #(
  parameter int M = 4,
  parameter int W = 32,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [W-1:0]  z_out,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  output logic          z_ack,
  output logic          collect_done,
  input  logic          rd_start,
  output logic [W-1:0]  rd_data,
  output logic [IW-1:0] rd_i,
  output logic [IW-1:0] rd_j,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic          rd_done,
  output logic          idx_err,
  output logic          dup_err
);
  localparam int AW = (M > 1) ? $clog2(M * M) : 1;
  localparam int CW = $clog2(M * M + 1);
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] FULL    = 2'd1;
  localparam logic [1:0] READ    = 2'd2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [M*M-1:0] r_bm;
  logic          r_ack;
  logic [IW-1:0] r_ri;
  logic [IW-1:0] r_rj;
  logic          r_done;
  logic          r_idx_err;
  logic [W-1:0]  r_mem [M*M];
  logic          w_cap;
  logic          w_inr;
  logic          w_new;
  logic          w_we;
  logic          w_xfer;
  logic          w_end;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_raddr;
  assign w_inr   = ({1'b0, z_i} < (IW+1)'(M)) && ({1'b0, z_j} < (IW+1)'(M));
  assign w_addr  = AW'(z_i) * AW'(M) + AW'(z_j);
  assign w_raddr = AW'(r_ri) * AW'(M) + AW'(r_rj);
  // a strobe still held while z_ack is high is the same request, not a new one
  assign w_cap   = (r_state == COLLECT) && z_stb && !r_ack && !clear;
  assign w_new   = w_cap && w_inr && !r_bm[w_addr];
  assign w_xfer  = rd_valid && rd_ready && !clear;
  assign w_end   = (r_ri == IW'(M-1)) && (r_rj == IW'(M-1));
`ifdef RESULT_DUP_CHECK_EN
  logic r_dup_err;
  assign w_we    = w_new;
  assign dup_err = r_dup_err;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_dup_err <= 1'b0;
    else if (w_cap && w_inr && r_bm[w_addr]) r_dup_err <= 1'b1;
`else
  assign w_we    = w_cap && w_inr;
  assign dup_err = 1'b0;
`endif
  assign z_ack        = r_ack;
  assign collect_done = r_state != COLLECT;
  assign rd_valid     = r_state == READ;
  assign rd_data      = rd_valid ? r_mem[w_raddr] : '0;
  assign rd_i         = r_ri;
  assign rd_j         = r_rj;
  assign rd_last      = rd_valid && w_end;
  assign rd_done      = r_done;
  assign idx_err      = r_idx_err;
  always_ff @(posedge clk)
    if (w_we) r_mem[w_addr] <= z_out;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= COLLECT;
      r_cnt     <= '0;
      r_bm      <= '0;
      r_ack     <= 1'b0;
      r_ri      <= '0;
      r_rj      <= '0;
      r_done    <= 1'b0;
      r_idx_err <= 1'b0;
    end else begin
      r_ack  <= w_cap;
      r_done <= 1'b0;
      if (w_cap && !w_inr) r_idx_err <= 1'b1;
      if (clear) begin
        r_state <= COLLECT;
        r_cnt   <= '0;
        r_bm    <= '0;
        r_ri    <= '0;
        r_rj    <= '0;
      end else begin
        if (w_new) begin
          r_bm[w_addr] <= 1'b1;
          r_cnt        <= r_cnt + CW'(1);
          if (r_cnt == CW'(M*M-1)) r_state <= FULL;
        end
        if (r_state == FULL && rd_start) begin
          r_state <= READ;
          r_ri    <= '0;
          r_rj    <= '0;
        end
        if (w_xfer) begin
          if (w_end) begin
            r_state <= FULL;
            r_done  <= 1'b1;
            r_ri    <= '0;
            r_rj    <= '0;
          end else if (r_rj == IW'(M-1)) begin
            r_rj <= '0;
            r_ri <= r_ri + IW'(1);
          end else r_rj <= r_rj + IW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_result_matrix_collector.sv
// tb_result_matrix_collector: directed stimulus with a cycle-level reference model and literal checks.
module tb_result_matrix_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] z_out = '0;
  logic [1:0]  z_i = '0;
  logic [1:0]  z_j = '0;
  logic        z_stb = 1'b0;
  logic        z_ack;
  logic        collect_done;
  logic        rd_start = 1'b0;
  logic [31:0] rd_data;
  logic [1:0]  rd_i;
  logic [1:0]  rd_j;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        rd_last;
  logic        rd_done;
  logic        idx_err;
  logic        dup_err;
  int n_chk = 0;
  int n_fail = 0;
  int got[$];
  int last_pos = -1;
  int done_pos = -1;
  int m_phase = 0;
  int m_cnt = 0;
  int m_k = 0;
  int m_val[16];
  bit m_wr[16];
  bit m_ack = 0;
  bit m_done = 0;
  bit m_idx_err = 0;
  bit m_dup_err = 0;
  result_matrix_collector #(.M(4), .W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear), .z_out(z_out), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .z_ack(z_ack), .collect_done(collect_done), .rd_start(rd_start),
    .rd_data(rd_data), .rd_i(rd_i), .rd_j(rd_j), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .rd_done(rd_done), .idx_err(idx_err), .dup_err(dup_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: matrix as a flat array, readout as a linear position 0..15
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_k = 0; m_ack = 0; m_done = 0;
      m_idx_err = 0; m_dup_err = 0;
      foreach (m_wr[a]) m_wr[a] = 0;
    end else begin
      automatic bit cap = (m_phase == 0) && z_stb && !m_ack && !clear;
      automatic bit nd = 0;
      automatic int a = int'(z_i) * 4 + int'(z_j);
      if (cap && (z_i > 3 || z_j > 3)) m_idx_err = 1;
      if (clear) begin
        m_phase = 0; m_cnt = 0; m_k = 0;
        foreach (m_wr[b]) m_wr[b] = 0;
      end else if (m_phase == 0) begin
        if (cap && !m_wr[a]) begin
          m_val[a] = int'(z_out); m_wr[a] = 1; m_cnt++;
          if (m_cnt == 16) m_phase = 1;
        end else if (cap) begin
`ifdef RESULT_DUP_CHECK_EN
          m_dup_err = 1;
`else
          m_val[a] = int'(z_out);
`endif
        end
      end else if (m_phase == 1) begin
        if (rd_start) begin m_phase = 2; m_k = 0; end
      end else if (rd_ready) begin
        if (m_k == 15) begin m_phase = 1; m_k = 0; nd = 1; end
        else m_k++;
      end
      m_ack = cap;
      m_done = nd;
    end
  end
  always @(negedge clk) begin
    chk("z_ack", z_ack, m_ack);
    chk("collect_done", collect_done, m_phase != 0);
    chk("rd_valid", rd_valid, m_phase == 2);
    chk("rd_last", rd_last, m_phase == 2 && m_k == 15);
    chk("rd_done", rd_done, m_done);
    chk("idx_err", idx_err, m_idx_err);
    chk("dup_err", dup_err, m_dup_err);
    if (m_phase == 2) begin
      chk("rd_i", rd_i, m_k / 4);
      chk("rd_j", rd_j, m_k % 4);
      chk("rd_data", rd_data, m_val[m_k]);
    end
    if (rd_done) done_pos = got.size();
    if (rd_valid && rd_ready) begin
      if (rd_last) last_pos = got.size();
      got.push_back(int'(rd_data));
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic strobe(input int i, input int j, input int v);
    automatic bit acked = 0;
    z_i = 2'(i); z_j = 2'(j); z_out = 32'(v); z_stb = 1'b1;
    for (int c = 0; c < 50 && !acked; c++) begin
      tick();
      acked = z_ack;
    end
    z_stb = 1'b0;
    chk("ack_seen", acked, 1);
  endtask
  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask
  task automatic read_all(input bit tog);
    got.delete(); last_pos = -1; done_pos = -1;
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("first_valid", rd_valid, 1);
    chk("first_ij", {rd_i, rd_j}, 0);
    for (int c = 0; c < 100 && done_pos < 0; c++) begin
      rd_ready = tog ? (c % 2 == 1) : 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("read_count", got.size(), 16);
    chk("last_pos", last_pos, 15);
    chk("done_pos", done_pos, 16);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #2;
    chk("rst_ack", z_ack, 0);
    chk("rst_done", collect_done, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_rdone", rd_done, 0);
    #20 rst = 1'b1;
    tick();
    // 1: in-order fill, full-rate readout
    for (int k = 0; k < 16; k++) begin
      strobe(k / 4, k % 4, k + 1);
      if (k == 14) chk("t1_not_done_15", collect_done, 0);
    end
    chk("t1_done_16", collect_done, 1);
    read_all(0);
    for (int k = 0; k < 16; k++) chk("t1_val", got[k], k + 1);
    // 3: re-read the same matrix with rd_ready toggling
    read_all(1);
    for (int k = 0; k < 16; k++) chk("t3_val", got[k], k + 1);
    // 2: reverse-order fill
    do_clear();
    for (int k = 15; k >= 0; k--) strobe(k / 4, k % 4, 200 + k);
    read_all(0);
    for (int k = 0; k < 16; k++) chk("t2_val", got[k], 200 + k);
    // 4: duplicate write to (1,2)
    do_clear();
    strobe(1, 2, 5);
    strobe(1, 2, 9);
    chk("t4_not_done", collect_done, 0);
    for (int k = 0; k < 16; k++) if (k != 6) strobe(k / 4, k % 4, k + 1);
    chk("t4_done", collect_done, 1);
    read_all(0);
`ifdef RESULT_DUP_CHECK_EN
    chk("t4_val12", got[6], 5);
    chk("t4_dup", dup_err, 1);
`else
    chk("t4_val12", got[6], 9);
    chk("t4_dup", dup_err, 0);
`endif
    // 5: strobe stalls while FULL, then clear after 7 captures
    z_i = 2'd0; z_j = 2'd0; z_out = 32'd77; z_stb = 1'b1;
    repeat (5) begin
      tick();
      chk("t5_no_ack", z_ack, 0);
    end
    do_clear();
    chk("t5_cleared", collect_done, 0);
    z_stb = 1'b0;
    strobe(0, 0, 77);
    for (int k = 1; k < 7; k++) strobe(k / 4, k % 4, 50 + k);
    do_clear();
    for (int k = 0; k < 16; k++) begin
      strobe(k / 4, k % 4, 300 + k);
      if (k == 14) chk("t5_refill_15", collect_done, 0);
    end
    chk("t5_refill_16", collect_done, 1);
    // 6: reset in the middle of a readout
    got.delete();
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 5; c++) tick();
    chk("t6_five", got.size(), 5);
    rst = 1'b0;
    #1;
    chk("t6_valid", rd_valid, 0);
    chk("t6_data", rd_data, 0);
    chk("t6_ij", {rd_i, rd_j}, 0);
    chk("t6_last", rd_last, 0);
    chk("t6_cdone", collect_done, 0);
    chk("t6_rdone", rd_done, 0);
    chk("t6_dup", dup_err, 0);
    rd_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("t6_start_ignored", rd_valid, 0);
    for (int k = 0; k < 16; k++) strobe(k / 4, k % 4, 100 + k);
    read_all(0);
    for (int k = 0; k < 16; k++) chk("t6_val", got[k], 100 + k);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
